// File: rtl/maxpool_layer_sequencer_if.sv
//==============================================================================
// Module   : maxpool_layer_sequencer_if
// Brief    : Config, upstream/downstream AXI-Stream and status bundle for the
//            maxpool layer sequencer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface maxpool_layer_sequencer_if #(
   parameter int DATA_WIDTH   = 256,
   parameter int COLS_WIDTH   = 10,
   parameter int BLOCKS_WIDTH = 10,
   parameter int CORES_WIDTH  = 8
);
   logic                    cfg_valid;
   logic                    cfg_ready;
   logic [COLS_WIDTH-1:0]   cfg_cols_m1;
   logic [BLOCKS_WIDTH-1:0] cfg_blocks_m1;
   logic [CORES_WIDTH-1:0]  cfg_cores_m1;
   logic                    cfg_pool_en;
   logic                    cfg_k3;

   logic                    s_axis_tvalid;
   logic                    s_axis_tready;
   logic [DATA_WIDTH-1:0]   s_axis_tdata;
   logic                    s_axis_tlast;

   logic                    m_axis_tvalid;
   logic                    m_axis_tready;
   logic [DATA_WIDTH-1:0]   m_axis_tdata;
   logic [5:0]              m_axis_tuser;
   logic                    m_axis_tlast;

   logic                    done;
   logic                    err_tlast;

   modport slave (
      input  cfg_valid, cfg_cols_m1, cfg_blocks_m1, cfg_cores_m1, cfg_pool_en, cfg_k3,
      output cfg_ready,
      input  s_axis_tvalid, s_axis_tdata, s_axis_tlast,
      output s_axis_tready,
      output m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast,
      input  m_axis_tready,
      output done, err_tlast
   );

   modport master (
      output cfg_valid, cfg_cols_m1, cfg_blocks_m1, cfg_cores_m1, cfg_pool_en, cfg_k3,
      input  cfg_ready,
      output s_axis_tvalid, s_axis_tdata, s_axis_tlast,
      input  s_axis_tready,
      input  m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast,
      output m_axis_tready,
      input  done, err_tlast
   );
endinterface

`default_nettype wire

// File: rtl/maxpool_layer_sequencer.sv
//==============================================================================
// Module   : maxpool_layer_sequencer
// Brief    : Per-layer pass-through controller generating tuser/tlast sideband
//            for the maxpool engine input stream.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module maxpool_layer_sequencer #(
   parameter int DATA_WIDTH   = 256,
   parameter int COLS_WIDTH   = 10,
   parameter int BLOCKS_WIDTH = 10,
   parameter int CORES_WIDTH  = 8
) (
   input  wire logic                 aclk,
   input  wire logic                 areset,
   maxpool_layer_sequencer_if.slave  bus
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;

   logic [COLS_WIDTH-1:0]   r_cols_m1;
   logic [BLOCKS_WIDTH-1:0] r_blocks_m1;
   logic [CORES_WIDTH-1:0]  r_cores_m1;
   logic                    r_pool_en;
   logic                    r_k3;

   logic [COLS_WIDTH-1:0]   r_col;
   logic [BLOCKS_WIDTH-1:0] r_block;
   logic [CORES_WIDTH-1:0]  r_core;

   logic                    r_done;
   logic                    r_err_tlast;

   logic                    w_run;
   logic                    w_cfg_fire;
   logic                    w_fire;
   logic                    w_core_last;
   logic                    w_col_last;
   logic                    w_block_last;
   logic                    w_layer_last;
   logic [DATA_WIDTH-1:0]   w_data;

   assign w_run        = (r_state == S_RUN);
   assign w_cfg_fire   = (r_state == S_IDLE) && bus.cfg_valid;
   assign w_fire       = w_run && bus.s_axis_tvalid && bus.m_axis_tready;
   assign w_core_last  = (r_core  == r_cores_m1);
   assign w_col_last   = (r_col   == r_cols_m1);
   assign w_block_last = (r_block == r_blocks_m1);
   assign w_layer_last = w_core_last && w_col_last && w_block_last;

   // Sideband and data are gated in IDLE so nothing leaks out before a layer starts.
   assign w_data             = w_run ? bus.s_axis_tdata : '0;
   assign bus.cfg_ready      = (r_state == S_IDLE);
   assign bus.s_axis_tready  = w_run && bus.m_axis_tready;
   assign bus.m_axis_tvalid  = w_run && bus.s_axis_tvalid;
   assign bus.m_axis_tdata   = w_data;
   assign bus.m_axis_tlast   = w_run && w_layer_last;
   assign bus.m_axis_tuser   = w_run ? {r_k3, r_pool_en, w_block_last, (r_block == '0),
                                        w_col_last, (r_col == '0)} : 6'b0;
   assign bus.done           = r_done;
   assign bus.err_tlast      = r_err_tlast;

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_cfg_fire) w_state_nxt = S_RUN;
         S_RUN:   if (w_fire && w_layer_last) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_cols_m1   <= '0;
         r_blocks_m1 <= '0;
         r_cores_m1  <= '0;
         r_pool_en   <= 1'b0;
         r_k3        <= 1'b0;
         r_col       <= '0;
         r_block     <= '0;
         r_core      <= '0;
         r_done      <= 1'b0;
         r_err_tlast <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_cfg_fire) begin
            r_cols_m1   <= bus.cfg_cols_m1;
            r_blocks_m1 <= bus.cfg_blocks_m1;
            r_cores_m1  <= bus.cfg_cores_m1;
            r_pool_en   <= bus.cfg_pool_en;
            r_k3        <= bus.cfg_k3;
            r_err_tlast <= 1'b0;
         end
         if (w_fire) begin
            // Upstream tlast is only policed; the generated one drives sequencing.
            if (bus.s_axis_tlast != w_layer_last) begin
               r_err_tlast <= 1'b1;
            end
            if (w_layer_last) begin
               r_core  <= '0;
               r_col   <= '0;
               r_block <= '0;
               r_done  <= 1'b1;
            end else if (w_core_last) begin
               r_core <= '0;
               if (w_col_last) begin
                  r_col   <= '0;
                  r_block <= r_block + 1'b1;
               end else begin
                  r_col <= r_col + 1'b1;
               end
            end else begin
               r_core <= r_core + 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_maxpool_layer_sequencer.sv
//==============================================================================
// Module   : tb_maxpool_layer_sequencer
// Brief    : Scoreboard bench for the maxpool layer sequencer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_maxpool_layer_sequencer;

   logic aclk = 1'b0;
   logic areset = 1'b1;
   always #5 aclk = ~aclk;

   maxpool_layer_sequencer_if #(
      .DATA_WIDTH(256), .COLS_WIDTH(10), .BLOCKS_WIDTH(10), .CORES_WIDTH(8)
   ) bus ();

   maxpool_layer_sequencer #(
      .DATA_WIDTH(256), .COLS_WIDTH(10), .BLOCKS_WIDTH(10), .CORES_WIDTH(8)
   ) dut (
      .aclk   (aclk),
      .areset (areset),
      .bus    (bus)
   );

   typedef struct {
      logic [255:0] data;
      logic [5:0]   tuser;
      logic         tlast;
   } exp_t;

   exp_t q[$];
   exp_t r_exp;
   int   n_tests = 0;
   int   n_fail  = 0;

   // next-layer config presented while the current layer runs
   int   nx_cols, nx_blocks, nx_cores;
   bit   nx_pool, nx_k3;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] pat(input int unsigned v);
      return {8{v}};
   endfunction

   always @(negedge aclk) begin
      if (!areset && bus.m_axis_tvalid && bus.m_axis_tready) begin
         if (q.size() == 0) begin
            check("unexpected_beat", 1, 0);
         end else begin
            r_exp = q.pop_front();
            check("tdata", bus.m_axis_tdata, r_exp.data);
            check("tuser", {250'b0, bus.m_axis_tuser}, {250'b0, r_exp.tuser});
            check("tlast", {255'b0, bus.m_axis_tlast}, {255'b0, r_exp.tlast});
         end
      end
   end

   task automatic run_layer(input int cols, input int blocks, input int cores,
                            input bit pool, input bit k3, input bit rnd_ready,
                            input int bad_beat, input int abort_at,
                            input bit hold, input bit expect_fast);
      int unsigned base;
      int          n, waits;
      bit          acc, rdy, fired;
      exp_t        e;
      base = $urandom;
      n    = (cols + 1) * (blocks + 1) * (cores + 1);
      for (int b = 0; b <= blocks; b++)
         for (int c = 0; c <= cols; c++)
            for (int k = 0; k <= cores; k++) begin
               e.data  = pat(base + 32'(b * (cols + 1) * (cores + 1) + c * (cores + 1) + k));
               e.tuser = {k3, pool, b == blocks, b == 0, c == cols, c == 0};
               e.tlast = (b == blocks) && (c == cols) && (k == cores);
               q.push_back(e);
            end

      bus.cfg_cols_m1   = 10'(cols);
      bus.cfg_blocks_m1 = 10'(blocks);
      bus.cfg_cores_m1  = 8'(cores);
      bus.cfg_pool_en   = pool;
      bus.cfg_k3        = k3;
      bus.cfg_valid     = 1'b1;
      acc   = 1'b0;
      waits = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge aclk);
         rdy = bus.cfg_ready;
         @(posedge aclk);
         #1;
         if (rdy) begin
            acc = 1'b1;
            break;
         end
         waits++;
      end
      check("cfg_accept", {255'b0, acc}, 1);
      if (expect_fast) check("cfg_accept_wait", 256'(waits), 0);
      check("err_clear_on_cfg", {255'b0, bus.err_tlast}, 0);
      if (hold) begin
         bus.cfg_cols_m1   = 10'(nx_cols);
         bus.cfg_blocks_m1 = 10'(nx_blocks);
         bus.cfg_cores_m1  = 8'(nx_cores);
         bus.cfg_pool_en   = nx_pool;
         bus.cfg_k3        = nx_k3;
      end else begin
         bus.cfg_valid = 1'b0;
      end

      for (int k = 0; k < n; k++) begin
         bus.s_axis_tvalid = 1'b1;
         bus.s_axis_tdata  = pat(base + 32'(k));
         bus.s_axis_tlast  = (bad_beat >= 0) ? (k == bad_beat) : (k == n - 1);
         fired = 1'b0;
         for (int a = 0; a < 200; a++) begin
            bus.m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge aclk);
            check("s_tready_mirror", {255'b0, bus.s_axis_tready}, {255'b0, bus.m_axis_tready});
            if (k == 0 && a == 0) check("cfg_ready_run", {255'b0, bus.cfg_ready}, 0);
            rdy = bus.m_axis_tready;
            @(posedge aclk);
            #1;
            if (rdy) begin
               fired = 1'b1;
               break;
            end
         end
         if (!fired) begin
            check("beat_timeout", 0, 1);
            bus.s_axis_tvalid = 1'b0;
            q.delete();
            return;
         end
         check("err_tlast", {255'b0, bus.err_tlast}, {255'b0, (bad_beat >= 0 && k >= bad_beat)});
         if (k == abort_at) begin
            areset            = 1'b1;
            bus.s_axis_tvalid = 1'b0;
            @(posedge aclk);
            #1;
            areset            = 1'b0;
            bus.s_axis_tvalid = 1'b1;
            #1;
            check("abort_cfg_ready", {255'b0, bus.cfg_ready}, 1);
            check("abort_m_tvalid", {255'b0, bus.m_axis_tvalid}, 0);
            check("abort_done", {255'b0, bus.done}, 0);
            bus.s_axis_tvalid = 1'b0;
            q.delete();
            return;
         end
         if (k == n - 1) begin
            check("done_pulse", {255'b0, bus.done}, 1);
            check("idle_cfg_ready", {255'b0, bus.cfg_ready}, 1);
            check("idle_m_tvalid", {255'b0, bus.m_axis_tvalid}, 0);
         end
      end
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;
      bus.m_axis_tready = 1'b1;
      check("queue_drained", 256'(q.size()), 0);
      if (!hold) begin
         @(posedge aclk);
         #1;
         check("done_one_cycle", {255'b0, bus.done}, 0);
         check("err_hold", {255'b0, bus.err_tlast}, {255'b0, (bad_beat >= 0)});
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cfg_valid     = 1'b0;
      bus.cfg_cols_m1   = '0;
      bus.cfg_blocks_m1 = '0;
      bus.cfg_cores_m1  = '0;
      bus.cfg_pool_en   = 1'b0;
      bus.cfg_k3        = 1'b0;
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = pat(32'hA5A5_5A5A);
      bus.s_axis_tlast  = 1'b1;
      bus.m_axis_tready = 1'b1;
      areset = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      check("rst_cfg_ready", {255'b0, bus.cfg_ready}, 1);
      check("rst_s_tready", {255'b0, bus.s_axis_tready}, 0);
      check("rst_m_tvalid", {255'b0, bus.m_axis_tvalid}, 0);
      check("rst_m_tdata", bus.m_axis_tdata, 0);
      check("rst_m_tuser", {250'b0, bus.m_axis_tuser}, 0);
      check("rst_m_tlast", {255'b0, bus.m_axis_tlast}, 0);
      check("rst_done", {255'b0, bus.done}, 0);
      check("rst_err", {255'b0, bus.err_tlast}, 0);
      areset = 1'b0;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;

      run_layer(2, 1, 1, 1'b1, 1'b1, 1'b0, -1, -1, 1'b0, 1'b0);
      run_layer(2, 1, 1, 1'b1, 1'b1, 1'b1, -1, -1, 1'b0, 1'b0);
      run_layer(0, 0, 0, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
      run_layer(2, 1, 1, 1'b1, 1'b0, 1'b0,  3, -1, 1'b0, 1'b0);
      run_layer(3, 0, 2, 1'b0, 1'b1, 1'b1, -1, -1, 1'b0, 1'b0);
      run_layer(2, 1, 1, 1'b1, 1'b1, 1'b0, -1,  5, 1'b0, 1'b0);
      run_layer(2, 1, 1, 1'b1, 1'b1, 1'b0, -1, -1, 1'b0, 1'b0);
      nx_cols = 1; nx_blocks = 2; nx_cores = 0; nx_pool = 1'b0; nx_k3 = 1'b1;
      run_layer(2, 1, 1, 1'b1, 1'b0, 1'b0, -1, -1, 1'b1, 1'b0);
      run_layer(1, 2, 0, 1'b0, 1'b1, 1'b1, -1, -1, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
